// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 control sequencer: opcodes, FSM states,
// ALU/extender selects and the decoded control vector.
package lc3_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_e;

  typedef enum logic [3:0] {
    S_FETCH,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_MEM_WAIT,
    S_WB,
    S_HALT,
    S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_AND   = 2'b01,
    ALU_NOT   = 2'b10,
    ALU_PASS1 = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    EXT_IMM5  = 2'b00,
    EXT_OFF6  = 2'b01,
    EXT_OFF9  = 2'b10,
    EXT_OFF11 = 2'b11
  } ext_sel_e;

  typedef struct packed {
    logic [1:0] alu;
    logic [1:0] ext;
    logic       reg_write;
    logic       sr2_mux;
    logic       dr_mux;
    logic       srpc_mux;
    logic       br_mux;
    logic       imm_sr2_mux;
    logic       jmp_mux;
    logic       is_mem;
    logic       is_load;
    logic       is_store;
    logic       is_ldi;
    logic       is_halt;
  } ctrl_t;

endpackage

// File: rtl/lc3_decode.sv
// Combinational decode of the instruction register into the datapath
// control vector used by the sequencer in EXEC and the memory states.
module lc3_decode
  import lc3_pkg::*;
#(
  parameter bit HALT_ON_TRAP = 1'b1
) (
  input  logic [15:0] ir,
  input  logic [2:0]  nzp_in,
  output ctrl_t       ctrl
);

  opcode_e op;
  logic    unused_ir_bits;

  assign op             = opcode_e'(ir[15:12]);
  assign unused_ir_bits = ^{ir[8:6], ir[4:0]};

  always_comb begin
    ctrl     = '0;
    ctrl.alu = ALU_ADD;
    ctrl.ext = EXT_IMM5;
    case (op)
      OP_ADD, OP_AND: begin
        ctrl.alu         = (op == OP_AND) ? ALU_AND : ALU_ADD;
        ctrl.imm_sr2_mux = ~ir[5];
        ctrl.ext         = EXT_IMM5;
        ctrl.reg_write   = 1'b1;
        ctrl.srpc_mux    = 1'b1;
      end
      OP_NOT: begin
        ctrl.alu       = ALU_NOT;
        ctrl.reg_write = 1'b1;
        ctrl.srpc_mux  = 1'b1;
      end
      OP_BR: begin
        // A branch with no condition bits set never matches: plain NOP.
        ctrl.br_mux  = |(ir[11:9] & nzp_in);
        ctrl.ext     = EXT_OFF9;
        ctrl.jmp_mux = 1'b1;
      end
      OP_JMP: begin
        ctrl.srpc_mux = 1'b1;
        ctrl.jmp_mux  = 1'b1;
      end
      OP_JSR: begin
        ctrl.dr_mux    = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.jmp_mux   = 1'b1;
        if (ir[11]) ctrl.ext = EXT_OFF11;
        else        ctrl.srpc_mux = 1'b1;
      end
      OP_LD, OP_LDI: begin
        ctrl.is_mem  = 1'b1;
        ctrl.is_load = 1'b1;
        ctrl.is_ldi  = (op == OP_LDI);
        ctrl.ext     = EXT_OFF9;
      end
      OP_LDR: begin
        ctrl.is_mem   = 1'b1;
        ctrl.is_load  = 1'b1;
        ctrl.ext      = EXT_OFF6;
        ctrl.srpc_mux = 1'b1;
      end
      OP_ST: begin
        ctrl.is_mem   = 1'b1;
        ctrl.is_store = 1'b1;
        ctrl.ext      = EXT_OFF9;
        ctrl.sr2_mux  = 1'b1;
      end
      OP_STR: begin
        ctrl.is_mem   = 1'b1;
        ctrl.is_store = 1'b1;
        ctrl.ext      = EXT_OFF6;
        ctrl.srpc_mux = 1'b1;
        ctrl.sr2_mux  = 1'b1;
      end
      OP_TRAP: ctrl.is_halt = HALT_ON_TRAP;
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_sequencer.sv
// Multi-cycle LC-3 control sequencer: fetch/decode/execute FSM with a
// memory handshake timeout, driving the datapath control strobes.
module lc3_sequencer
  import lc3_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 255,
  parameter bit HALT_ON_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instruction,
  input  logic        mem_ready,
  input  logic [2:0]  nzp_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ExtByHowMuch,
  output logic        RegWrite,
  output logic        PtrToPtr,
  output logic        SR2Mux,
  output logic        DRMux,
  output logic        RegWriteMux,
  output logic        SRPCMux,
  output logic        BrMux,
  output logic        ImmSR2Mux,
  output logic        JMPMux,
  output logic        pc_en,
  output logic        ir_load,
  output logic        halted,
  output logic        fault
);

  localparam int CNT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state, state_next;
  logic [15:0]      ir;
  logic [CNT_W-1:0] cnt;
  logic             started;
  logic             ldi_second, ldi_second_next;
  logic             wait_state, timed_out;
  ctrl_t            dec;

  lc3_decode #(.HALT_ON_TRAP(HALT_ON_TRAP)) u_decode (
    .ir    (ir),
    .nzp_in(nzp_in),
    .ctrl  (dec)
  );

  assign wait_state = (state == S_FETCH_WAIT) || (state == S_MEM_WAIT);
  assign timed_out  = wait_state && !mem_ready && (cnt == TIMEOUT_LAST);

  // started holds every output low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      ir         <= '0;
      cnt        <= '0;
      started    <= 1'b0;
      ldi_second <= 1'b0;
    end else begin
      started    <= 1'b1;
      state      <= state_next;
      ldi_second <= ldi_second_next;
      if (ir_load) ir <= instruction;
      if (wait_state) cnt <= cnt + CNT_W'(1);
      else            cnt <= '0;
    end
  end

  always_comb begin
    state_next      = state;
    ldi_second_next = ldi_second;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    ALUControl      = ALU_ADD;
    ExtByHowMuch    = EXT_IMM5;
    RegWrite        = 1'b0;
    PtrToPtr        = 1'b0;
    SR2Mux          = 1'b0;
    DRMux           = 1'b0;
    RegWriteMux     = 1'b0;
    SRPCMux         = 1'b0;
    BrMux           = 1'b0;
    ImmSR2Mux       = 1'b0;
    JMPMux          = 1'b0;
    pc_en           = 1'b0;
    ir_load         = 1'b0;
    halted          = 1'b0;
    fault           = 1'b0;
    if (started) begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          ALUControl = ALU_PASS1;
          state_next = S_FETCH_WAIT;
        end
        S_FETCH_WAIT: begin
          mem_req    = 1'b1;
          ALUControl = ALU_PASS1;
          if (mem_ready) begin
            ir_load    = 1'b1;
            state_next = S_DECODE;
          end else if (timed_out) begin
            state_next = S_FAULT;
          end
        end
        S_DECODE: state_next = dec.is_halt ? S_HALT : S_EXEC;
        S_EXEC: begin
          ALUControl   = dec.alu;
          ExtByHowMuch = dec.ext;
          SRPCMux      = dec.srpc_mux;
          ImmSR2Mux    = dec.imm_sr2_mux;
          if (dec.is_mem) begin
            ldi_second_next = 1'b0;
            state_next      = S_MEM;
          end else begin
            RegWrite   = dec.reg_write;
            DRMux      = dec.dr_mux;
            BrMux      = dec.br_mux;
            JMPMux     = dec.jmp_mux;
            pc_en      = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_MEM, S_MEM_WAIT: begin
          // Address selects stay as in EXEC for the whole access.
          mem_req      = 1'b1;
          mem_we       = dec.is_store;
          SR2Mux       = dec.sr2_mux;
          ALUControl   = dec.alu;
          ExtByHowMuch = dec.ext;
          SRPCMux      = dec.srpc_mux;
          ImmSR2Mux    = dec.imm_sr2_mux;
          PtrToPtr     = ldi_second;
          if (state == S_MEM) begin
            state_next = S_MEM_WAIT;
          end else if (mem_ready) begin
            if (dec.is_ldi && !ldi_second) begin
              ldi_second_next = 1'b1;
              state_next      = S_MEM;
            end else if (dec.is_load) begin
              state_next = S_WB;
            end else begin
              pc_en      = 1'b1;
              state_next = S_FETCH;
            end
          end else if (timed_out) begin
            state_next = S_FAULT;
          end
        end
        S_WB: begin
          RegWrite        = 1'b1;
          RegWriteMux     = 1'b1;
          pc_en           = 1'b1;
          ldi_second_next = 1'b0;
          state_next      = S_FETCH;
        end
        S_HALT:  halted = 1'b1;
        S_FAULT: fault  = 1'b1;
        default: state_next = S_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_sequencer.sv
// Directed bench for lc3_sequencer: one task per scenario, hand-computed
// expectations; a second instance built with HALT_ON_TRAP=0 covers TRAP-as-NOP.
module tb_lc3_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic        mem_ready = 1'b0;
  logic [2:0]  nzp_in = 3'b000;

  logic       mem_req, mem_we, RegWrite, PtrToPtr, SR2Mux, DRMux, RegWriteMux;
  logic       SRPCMux, BrMux, ImmSR2Mux, JMPMux, pc_en, ir_load, halted, fault;
  logic [1:0] ALUControl, ExtByHowMuch;

  logic       n_mem_req, n_mem_we, n_RegWrite, n_PtrToPtr, n_SR2Mux, n_DRMux, n_RegWriteMux;
  logic       n_SRPCMux, n_BrMux, n_ImmSR2Mux, n_JMPMux, n_pc_en, n_ir_load, n_halted, n_fault;
  logic [1:0] n_ALUControl, n_ExtByHowMuch;

  logic [18:0] outs;
  int n_tests = 0;
  int n_fail  = 0;
  int pc_count = 0;

  assign outs = {mem_req, mem_we, ALUControl, ExtByHowMuch, RegWrite, PtrToPtr, SR2Mux,
                 DRMux, RegWriteMux, SRPCMux, BrMux, ImmSR2Mux, JMPMux, pc_en, ir_load,
                 halted, fault};

  lc3_sequencer #(.MEM_TIMEOUT(255), .HALT_ON_TRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready),
    .nzp_in(nzp_in), .mem_req(mem_req), .mem_we(mem_we), .ALUControl(ALUControl),
    .ExtByHowMuch(ExtByHowMuch), .RegWrite(RegWrite), .PtrToPtr(PtrToPtr),
    .SR2Mux(SR2Mux), .DRMux(DRMux), .RegWriteMux(RegWriteMux), .SRPCMux(SRPCMux),
    .BrMux(BrMux), .ImmSR2Mux(ImmSR2Mux), .JMPMux(JMPMux), .pc_en(pc_en),
    .ir_load(ir_load), .halted(halted), .fault(fault)
  );

  lc3_sequencer #(.MEM_TIMEOUT(255), .HALT_ON_TRAP(1'b0)) dut_nop (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready),
    .nzp_in(nzp_in), .mem_req(n_mem_req), .mem_we(n_mem_we), .ALUControl(n_ALUControl),
    .ExtByHowMuch(n_ExtByHowMuch), .RegWrite(n_RegWrite), .PtrToPtr(n_PtrToPtr),
    .SR2Mux(n_SR2Mux), .DRMux(n_DRMux), .RegWriteMux(n_RegWriteMux), .SRPCMux(n_SRPCMux),
    .BrMux(n_BrMux), .ImmSR2Mux(n_ImmSR2Mux), .JMPMux(n_JMPMux), .pc_en(n_pc_en),
    .ir_load(n_ir_load), .halted(n_halted), .fault(n_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pc_en === 1'b1) pc_count <= pc_count + 1;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Called in a FETCH cycle; returns in the DECODE cycle.
  task automatic fetch_instr(input logic [15:0] instr, input int waits);
    instruction = instr; mem_ready = 1'b0;
    tick();
    repeat (waits) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_tests++; if (outs !== 19'h0) begin n_fail++; $display("FAIL reset_outs got=%h exp=0", outs); end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_tests++; if (outs !== 19'h0) begin n_fail++; $display("FAIL reset_release_before_edge got=%h exp=0", outs); end
    tick();
    n_tests++; if (mem_req !== 1'b1 || ALUControl !== 2'b11 || SRPCMux !== 1'b0 || mem_we !== 1'b0)
      begin n_fail++; $display("FAIL reset_first_fetch got req=%b alu=%b exp req=1 alu=11", mem_req, ALUControl); end
  endtask

  task automatic test_add();
    int p0;
    int cycles;
    p0 = pc_count; cycles = 1;
    instruction = 16'h1261; mem_ready = 1'b0;
    tick(); cycles++;
    n_tests++; if (mem_req !== 1'b1 || ir_load !== 1'b0) begin n_fail++; $display("FAIL add_fetch_wait got req=%b ld=%b exp 1 0", mem_req, ir_load); end
    mem_ready = 1'b1; #1;
    n_tests++; if (ir_load !== 1'b1) begin n_fail++; $display("FAIL add_ir_load got=%b exp=1", ir_load); end
    tick(); cycles++; mem_ready = 1'b0;
    n_tests++; if (outs !== 19'h0) begin n_fail++; $display("FAIL add_decode_quiet got=%h exp=0", outs); end
    tick(); cycles++;
    n_tests++; if (RegWrite !== 1'b1 || ImmSR2Mux !== 1'b0 || pc_en !== 1'b1 || ALUControl !== 2'b00 ||
                   ExtByHowMuch !== 2'b00 || SRPCMux !== 1'b1 || RegWriteMux !== 1'b0)
      begin n_fail++; $display("FAIL add_exec got rw=%b imm=%b pc=%b alu=%b exp 1 0 1 00", RegWrite, ImmSR2Mux, pc_en, ALUControl); end
    tick();
    n_tests++; if (mem_req !== 1'b1 || pc_en !== 1'b0) begin n_fail++; $display("FAIL add_back_to_fetch after %0d cycles got req=%b exp=1", cycles, mem_req); end
    n_tests++; if (pc_count - p0 !== 1) begin n_fail++; $display("FAIL add_pc_once got=%0d exp=1", pc_count - p0); end
  endtask

  task automatic test_branch();
    nzp_in = 3'b010;
    fetch_instr(16'h0402, 0); tick();
    n_tests++; if (BrMux !== 1'b1 || pc_en !== 1'b1 || JMPMux !== 1'b1 || ExtByHowMuch !== 2'b10 || SRPCMux !== 1'b0)
      begin n_fail++; $display("FAIL brz_taken got br=%b pc=%b ext=%b exp 1 1 10", BrMux, pc_en, ExtByHowMuch); end
    tick();
    nzp_in = 3'b100;
    fetch_instr(16'h0402, 1); tick();
    n_tests++; if (BrMux !== 1'b0 || pc_en !== 1'b1) begin n_fail++; $display("FAIL brz_not_taken got br=%b pc=%b exp 0 1", BrMux, pc_en); end
    tick();
    nzp_in = 3'b111;
    fetch_instr(16'h0002, 0); tick();
    n_tests++; if (BrMux !== 1'b0 || pc_en !== 1'b1 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL br_000_nop got br=%b pc=%b exp 0 1", BrMux, pc_en); end
    tick();
    nzp_in = 3'b000;
  endtask

  task automatic test_jump();
    fetch_instr(16'h4801, 0); tick();
    n_tests++; if (DRMux !== 1'b1 || RegWrite !== 1'b1 || JMPMux !== 1'b1 || ExtByHowMuch !== 2'b11 || pc_en !== 1'b1 || SRPCMux !== 1'b0)
      begin n_fail++; $display("FAIL jsr_exec got dr=%b rw=%b jmp=%b ext=%b exp 1 1 1 11", DRMux, RegWrite, JMPMux, ExtByHowMuch); end
    tick();
    fetch_instr(16'hC080, 0); tick();
    n_tests++; if (SRPCMux !== 1'b1 || ImmSR2Mux !== 1'b0 || BrMux !== 1'b0 || JMPMux !== 1'b1 || pc_en !== 1'b1 || RegWrite !== 1'b0)
      begin n_fail++; $display("FAIL jmp_exec got srpc=%b jmp=%b pc=%b rw=%b exp 1 1 1 0", SRPCMux, JMPMux, pc_en, RegWrite); end
    tick();
  endtask

  task automatic test_not_nop();
    fetch_instr(16'h927F, 0);
    mem_ready = 1'b1;
    tick(); #1;
    n_tests++; if (ALUControl !== 2'b10 || RegWrite !== 1'b1 || pc_en !== 1'b1 || ir_load !== 1'b0)
      begin n_fail++; $display("FAIL not_exec got alu=%b rw=%b pc=%b ld=%b exp 10 1 1 0", ALUControl, RegWrite, pc_en, ir_load); end
    mem_ready = 1'b0;
    tick();
    fetch_instr(16'hD123, 0); tick();
    n_tests++; if (pc_en !== 1'b1 || RegWrite !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL unimpl_nop got pc=%b rw=%b exp 1 0", pc_en, RegWrite); end
    tick();
  endtask

  task automatic test_ldi();
    int p0;
    p0 = pc_count;
    fetch_instr(16'hA005, 0); tick();
    n_tests++; if (pc_en !== 1'b0 || ExtByHowMuch !== 2'b10 || mem_req !== 1'b0) begin n_fail++; $display("FAIL ldi_exec got pc=%b ext=%b exp 0 10", pc_en, ExtByHowMuch); end
    tick();
    n_tests++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || PtrToPtr !== 1'b0) begin n_fail++; $display("FAIL ldi_mem1 got req=%b we=%b ptr=%b exp 1 0 0", mem_req, mem_we, PtrToPtr); end
    tick(); mem_ready = 1'b1; #1;
    n_tests++; if (PtrToPtr !== 1'b0 || ExtByHowMuch !== 2'b10 || pc_en !== 1'b0) begin n_fail++; $display("FAIL ldi_wait1 got ptr=%b ext=%b exp 0 10", PtrToPtr, ExtByHowMuch); end
    tick(); mem_ready = 1'b0;
    n_tests++; if (mem_req !== 1'b1 || PtrToPtr !== 1'b1) begin n_fail++; $display("FAIL ldi_mem2 got req=%b ptr=%b exp 1 1", mem_req, PtrToPtr); end
    tick();
    n_tests++; if (PtrToPtr !== 1'b1 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL ldi_wait2 got ptr=%b rw=%b exp 1 0", PtrToPtr, RegWrite); end
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    n_tests++; if (RegWrite !== 1'b1 || RegWriteMux !== 1'b1 || DRMux !== 1'b0 || pc_en !== 1'b1 || mem_req !== 1'b0)
      begin n_fail++; $display("FAIL ldi_wb got rw=%b rwm=%b pc=%b exp 1 1 1", RegWrite, RegWriteMux, pc_en); end
    tick();
    n_tests++; if (mem_req !== 1'b1 || pc_count - p0 !== 1) begin n_fail++; $display("FAIL ldi_retire got req=%b pcs=%0d exp 1 1", mem_req, pc_count - p0); end
  endtask

  task automatic test_store();
    fetch_instr(16'h7040, 0); tick();
    n_tests++; if (pc_en !== 1'b0 || SRPCMux !== 1'b1 || ExtByHowMuch !== 2'b01) begin n_fail++; $display("FAIL str_exec got pc=%b srpc=%b ext=%b exp 0 1 01", pc_en, SRPCMux, ExtByHowMuch); end
    tick();
    n_tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || SR2Mux !== 1'b1) begin n_fail++; $display("FAIL str_mem got req=%b we=%b sr2=%b exp 1 1 1", mem_req, mem_we, SR2Mux); end
    tick(); mem_ready = 1'b1; #1;
    n_tests++; if (pc_en !== 1'b1 || mem_we !== 1'b1 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL str_retire got pc=%b we=%b exp 1 1", pc_en, mem_we); end
    tick(); mem_ready = 1'b0;
    n_tests++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL str_next_fetch got req=%b we=%b exp 1 0", mem_req, mem_we); end
  endtask

  task automatic test_reset_mid_fetch();
    tick();
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_in_wait got req=%b exp=1", mem_req); end
    #1 rst_n = 1'b0; #1;
    n_tests++; if (outs !== 19'h0) begin n_fail++; $display("FAIL midrst_outs_now got=%h exp=0", outs); end
    tick();
    rst_n = 1'b1;
    tick();
    n_tests++; if (mem_req !== 1'b1 || ALUControl !== 2'b11 || ir_load !== 1'b0 || pc_en !== 1'b0)
      begin n_fail++; $display("FAIL midrst_fetch got req=%b alu=%b exp 1 11", mem_req, ALUControl); end
  endtask

  task automatic test_trap();
    fetch_instr(16'hF025, 0); tick();
    n_tests++; if (halted !== 1'b1 || pc_en !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL trap_halt got halted=%b pc=%b exp 1 0", halted, pc_en); end
    n_tests++; if (n_pc_en !== 1'b1 || n_halted !== 1'b0 || n_RegWrite !== 1'b0) begin n_fail++; $display("FAIL trap_nop got pc=%b halted=%b exp 1 0", n_pc_en, n_halted); end
    mem_ready = 1'b1;
    repeat (4) tick();
    mem_ready = 1'b0;
    n_tests++; if (halted !== 1'b1 || outs !== 19'h2) begin n_fail++; $display("FAIL trap_terminal got outs=%h exp=00002", outs); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    fetch_instr(16'h3005, 0); tick(); tick();
    n = 0;
    while (fault !== 1'b1 && n < 400) begin
      if (mem_req === 1'b1) n++;
      tick();
    end
    n_tests++; if (fault !== 1'b1 || n !== 256) begin n_fail++; $display("FAIL st_timeout got fault=%b req_cycles=%0d exp 1 256", fault, n); end
    mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    n_tests++; if (fault !== 1'b1 || mem_req !== 1'b0 || halted !== 1'b0 || pc_en !== 1'b0)
      begin n_fail++; $display("FAIL fault_terminal got fault=%b req=%b exp 1 0", fault, mem_req); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_jump();
    test_not_nop();
    test_ldi();
    test_store();
    test_reset_mid_fetch();
    test_trap();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
